// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch sequencer with run/pause, clear, field adjust and blink flags
module stopwatch_ctrl #(
    parameter int ADJ_DIV   = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz,
    input  logic       thirty_two_hz,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running
);
    localparam int AW = $clog2(ADJ_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;
    state_t        state_q, state_d;
    logic          saved_run_q, saved_run_d;
    logic [1:0]    prev_q, prev_d;
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    hist_q, hist_d;
    logic [AW-1:0] adj_cnt_q, adj_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [7:0]    min_q, min_d, sec_q, sec_d;
    logic          blank_min_q, blank_min_d, blank_sec_q, blank_sec_d;
    logic          running_q, running_d;
    logic          one_edge, fast_edge, pause_edge, clr_edge, adj_on, sel;
    logic          in_adj, fast_tick, adj_wrap, blink_wrap, sec_inc, min_inc;

    function automatic logic [7:0] inc_bcd(input logic [7:0] v);
        return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                              : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Edge detection and synchronizer chains; sync bits are {sel, adj, clr, pause}
    always_comb begin
        prev_d     = {thirty_two_hz, one_hz};
        sync1_d    = {sw_sel, sw_adj, btn_clr, btn_pause};
        sync2_d    = sync1_q;
        hist_d     = sync2_q[1:0];
        one_edge   = one_hz & ~prev_q[0];
        fast_edge  = thirty_two_hz & ~prev_q[1];
        pause_edge = sync2_q[0] & ~hist_q[0];
        clr_edge   = sync2_q[1] & ~hist_q[1];
        adj_on     = sync2_q[2];
        sel        = sync2_q[3];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAUSED;
            saved_run_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_run_q <= saved_run_d;
        end
    end

    // Next state: adjust switch dominates pause presses; exit restores the pre-adjust state
    always_comb begin
        state_d     = state_q;
        saved_run_d = saved_run_q;
        case (state_q)
            PAUSED: if (adj_on) begin
                state_d     = ADJUST;
                saved_run_d = 1'b0;
            end else if (pause_edge) state_d = RUN;
            RUN: if (adj_on) begin
                state_d     = ADJUST;
                saved_run_d = 1'b1;
            end else if (pause_edge) state_d = PAUSED;
            ADJUST: if (!adj_on) state_d = saved_run_q ? RUN : PAUSED;
            default: state_d = PAUSED;
        endcase
    end

    // Datapath and output next values; clear beats any same-cycle increment
    always_comb begin
        in_adj      = state_q == ADJUST;
        fast_tick   = in_adj & fast_edge;
        adj_wrap    = fast_tick && adj_cnt_q == AW'(ADJ_DIV - 1);
        blink_wrap  = fast_tick && blink_cnt_q == BW'(BLINK_DIV - 1);
        adj_cnt_d   = !in_adj ? '0 : !fast_tick ? adj_cnt_q : adj_wrap ? '0 : adj_cnt_q + 1'b1;
        blink_cnt_d = !in_adj ? '0 : !fast_tick ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_d     = in_adj & (blink_q ^ blink_wrap);
        sec_inc     = (state_q == RUN && one_edge) || (adj_wrap && sel);
        min_inc     = (state_q == RUN && one_edge && sec_q == 8'h59) || (adj_wrap && !sel);
        sec_d       = clr_edge ? 8'h00 : sec_inc ? inc_bcd(sec_q) : sec_q;
        min_d       = clr_edge ? 8'h00 : min_inc ? inc_bcd(min_q) : min_q;
        blank_min_d = state_d == ADJUST && blink_d && !sel;
        blank_sec_d = state_d == ADJUST && blink_d && sel;
        running_d   = state_d == RUN;
    end

    // Datapath, synchronizer and output registers; tick history resets high to suppress a release edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= 2'b11;
            sync1_q     <= '0;
            sync2_q     <= '0;
            hist_q      <= '0;
            adj_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            min_q       <= '0;
            sec_q       <= '0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            adj_cnt_q   <= adj_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            running_q   <= running_d;
        end
    end

    assign min_tens  = min_q[7:4];
    assign min_ones  = min_q[3:0];
    assign sec_tens  = sec_q[7:4];
    assign sec_ones  = sec_q[3:0];
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
    assign running   = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenario bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst, one_hz, thirty_two_hz, btn_pause, btn_clr, sw_adj, sw_sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic blank_min, blank_sec, running;
    logic [15:0] t;
    int checks = 0;
    int errors = 0;

    stopwatch_ctrl dut (
        .clk(clk), .rst(rst), .one_hz(one_hz), .thirty_two_hz(thirty_two_hz),
        .btn_pause(btn_pause), .btn_clr(btn_clr), .sw_adj(sw_adj), .sw_sel(sw_sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
    );

    always #5 clk = ~clk;
    assign t = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic do_reset();
        rst = 1'b1; one_hz = 1'b0; thirty_two_hz = 1'b0;
        btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk) btn_pause = 1'b1;
        repeat (4) @(negedge clk);
        btn_pause = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) one_hz = 1'b1;
            @(negedge clk) one_hz = 1'b0;
        end
    endtask

    task automatic pulse_32(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) thirty_two_hz = 1'b1;
            @(negedge clk) thirty_two_hz = 1'b0;
        end
    endtask

    task automatic set_adj(input logic a, input logic s);
        @(negedge clk) begin sw_adj = a; sw_sel = s; end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; one_hz = 1'b1; thirty_two_hz = 1'b1;
        btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({t, blank_min, blank_sec, running} !== 19'h0) begin
            errors++; $display("FAIL reset_outputs: got %h/%b%b%b want 0000/000", t, blank_min, blank_sec, running);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        press_pause();
        checks++;
        if (t !== 16'h0000 || running !== 1'b1) begin
            errors++; $display("FAIL one_hz_high_at_release: got %h run=%b want 0000 run=1", t, running);
        end
        thirty_two_hz = 1'b0;
        @(negedge clk) one_hz = 1'b0;
    endtask

    task automatic test_count();
        pulse_1hz(61);
        checks++;
        if (t !== 16'h0101 || running !== 1'b1) begin
            errors++; $display("FAIL count_61: got %h run=%b want 0101 run=1", t, running);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        set_adj(1'b1, 1'b0);
        pulse_32(944);
        checks++;
        if (t !== 16'h5900) begin
            errors++; $display("FAIL adjust_minutes: got %h want 5900", t);
        end
        set_adj(1'b1, 1'b1);
        pulse_32(944);
        checks++;
        if (t !== 16'h5959) begin
            errors++; $display("FAIL adjust_seconds: got %h want 5959", t);
        end
        set_adj(1'b0, 1'b1);
        checks++;
        if (running !== 1'b0 || t !== 16'h5959) begin
            errors++; $display("FAIL exit_to_paused: got %h run=%b want 5959 run=0", t, running);
        end
        press_pause();
        @(negedge clk) one_hz = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (t !== 16'h0000 || running !== 1'b1) begin
            errors++; $display("FAIL wrap_5959: got %h run=%b want 0000 run=1", t, running);
        end
        @(negedge clk) one_hz = 1'b0;
    endtask

    task automatic test_adjust();
        do_reset();
        press_pause();
        pulse_1hz(58);
        press_pause();
        checks++;
        if (t !== 16'h0058 || running !== 1'b0) begin
            errors++; $display("FAIL preload_0058: got %h run=%b want 0058 run=0", t, running);
        end
        set_adj(1'b1, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            pulse_32(1);
            if (i == 4) begin
                pulse_1hz(3);
                press_pause();
                checks++;
                if (t !== 16'h0058) begin
                    errors++; $display("FAIL one_hz_ignored: got %h want 0058", t);
                end
            end
            if (i % 8 == 0) begin
                checks++;
                if (blank_sec !== ((i / 8) % 2 == 1) || blank_min !== 1'b0) begin
                    errors++; $display("FAIL blink_edge%0d: got min=%b sec=%b want min=0 sec=%b", i, blank_min, blank_sec, (i / 8) % 2);
                end
            end
            if (i == 16) begin
                checks++;
                if (t !== 16'h0059) begin
                    errors++; $display("FAIL adj_inc16: got %h want 0059", t);
                end
            end
        end
        checks++;
        if (t !== 16'h0000) begin
            errors++; $display("FAIL adj_wrap_sec: got %h want 0000", t);
        end
        set_adj(1'b1, 1'b0);
        pulse_32(8);
        checks++;
        if (t !== 16'h0000 || blank_min !== 1'b1 || blank_sec !== 1'b0) begin
            errors++; $display("FAIL sel_min_blink: got %h min=%b sec=%b want 0000 min=1 sec=0", t, blank_min, blank_sec);
        end
        pulse_32(8);
        checks++;
        if (t !== 16'h0100 || blank_min !== 1'b0) begin
            errors++; $display("FAIL sel_keeps_cnt: got %h min=%b want 0100 min=0", t, blank_min);
        end
        set_adj(1'b0, 1'b0);
        checks++;
        if (running !== 1'b0 || blank_min !== 1'b0 || blank_sec !== 1'b0) begin
            errors++; $display("FAIL adj_exit_paused: got run=%b blanks=%b%b want 0 00", running, blank_min, blank_sec);
        end
    endtask

    task automatic test_adjust_from_run();
        do_reset();
        press_pause();
        set_adj(1'b1, 1'b0);
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL adj_from_run_enter: got run=%b want 0", running);
        end
        set_adj(1'b0, 1'b0);
        pulse_1hz(1);
        checks++;
        if (running !== 1'b1 || t !== 16'h0001) begin
            errors++; $display("FAIL adj_from_run_exit: got %h run=%b want 0001 run=1", t, running);
        end
    endtask

    task automatic test_clear();
        do_reset();
        set_adj(1'b1, 1'b0);
        pulse_32(192);
        set_adj(1'b1, 1'b1);
        pulse_32(544);
        set_adj(1'b0, 1'b1);
        press_pause();
        checks++;
        if (t !== 16'h1234 || running !== 1'b1) begin
            errors++; $display("FAIL preload_1234: got %h run=%b want 1234 run=1", t, running);
        end
        @(negedge clk) btn_clr = 1'b1;
        @(negedge clk);
        @(negedge clk) one_hz = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (t !== 16'h0000) begin
            errors++; $display("FAIL clr_vs_tick: got %h want 0000", t);
        end
        @(negedge clk) begin one_hz = 1'b0; btn_clr = 1'b0; end
        pulse_1hz(1);
        checks++;
        if (t !== 16'h0001 || running !== 1'b1) begin
            errors++; $display("FAIL clr_keeps_state: got %h run=%b want 0001 run=1", t, running);
        end
    endtask

    task automatic test_pause_tick();
        do_reset();
        press_pause();
        pulse_1hz(5);
        @(negedge clk) btn_pause = 1'b1;
        @(negedge clk);
        @(negedge clk) one_hz = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (t !== 16'h0006 || running !== 1'b0) begin
            errors++; $display("FAIL pause_tick_run: got %h run=%b want 0006 run=0", t, running);
        end
        @(negedge clk) begin one_hz = 1'b0; btn_pause = 1'b0; end
        repeat (4) @(negedge clk);
        btn_pause = 1'b1;
        @(negedge clk);
        @(negedge clk) one_hz = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (t !== 16'h0006 || running !== 1'b1) begin
            errors++; $display("FAIL pause_tick_paused: got %h run=%b want 0006 run=1", t, running);
        end
        @(negedge clk) begin one_hz = 1'b0; btn_pause = 1'b0; end
    endtask

    task automatic test_async_reset();
        set_adj(1'b1, 1'b1);
        pulse_32(8);
        checks++;
        if (blank_sec !== 1'b1 || t !== 16'h0006) begin
            errors++; $display("FAIL pre_reset_adjust: got %h sec=%b want 0006 sec=1", t, blank_sec);
        end
        @(negedge clk) #1 rst = 1'b1;
        #1;
        checks++;
        if ({t, blank_min, blank_sec, running} !== 19'h0) begin
            errors++; $display("FAIL async_reset: got %h/%b%b%b want 0000/000", t, blank_min, blank_sec, running);
        end
        sw_adj = 1'b0; sw_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_adjust();
        test_adjust_from_run();
        test_clear();
        test_pause_tick();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
